root_drain: RTL and testbench

- Downstream companion of the pipelined 8-bit integer square-root stage. Its ports are named In_X and Root_C.
- Tracks which ROOT pipeline slots carry real data, using a valid/X shift register matched to ROOT latency.
- Computes the remainder X - C*C for each valid result.
- Buffers {X, C, R} in a small FIFO with a ready/valid output.
- ROOT cannot stall, so In_ready is issued on credits: it covers queued entries plus in-flight entries.

---
 rtl/root_drain.sv | 127 ++++++++++++
 tb/tb_root_drain.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/root_drain.sv
// Drain stage behind the pipelined 8-bit square-root block: valid/X tracking, remainder, credit-flow FIFO.
// Optional ROOT_CHECK_EN adds a sticky Chk_err output that flags implausible ROOT results.
module root_drain #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4,
  parameter int AW      = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       In_valid,
  input  logic [7:0] In_X,
  output logic       In_ready,
  input  logic [7:0] Root_C,
  output logic       Out_valid,
  input  logic       Out_ready,
  output logic [7:0] Out_X,
  output logic [3:0] Out_C,
  output logic [4:0] Out_R
`ifdef ROOT_CHECK_EN
  ,
  output logic       Chk_err
`endif
);

  typedef struct packed {
    logic [7:0] x;
    logic [3:0] c;
    logic [4:0] r;
  } entry_t;

  logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [7:0]         x_sr_q [LATENCY];
  logic [7:0]         x_sr_d [LATENCY];
  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;

  logic       accept, wr_en, rd_en;
  logic [7:0] x_tail, sq;
  logic [3:0] c_tail;
  logic [4:0] rem;
  int         inflight;

  always_comb begin
    x_tail = x_sr_q[LATENCY-1];
    c_tail = Root_C[3:0];
    sq     = {4'b0000, c_tail} * {4'b0000, c_tail};
    rem    = x_tail[4:0] - sq[4:0];

    // Credit covers both queued and in-flight slots, since ROOT cannot be stalled.
    inflight = 0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + int'(vld_sr_q[i]);
    In_ready = (int'(count_q) + inflight) < DEPTH;

    accept = In_valid && In_ready;
    wr_en  = vld_sr_q[LATENCY-1];
    rd_en  = Out_ready && (count_q != '0);

    vld_sr_d[0] = accept;
    x_sr_d[0]   = accept ? In_X : 8'h00;
    for (int i = 1; i < LATENCY; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
      x_sr_d[i]   = x_sr_q[i-1];
    end

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = '{x: x_tail, c: c_tail, r: rem};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    count_d = count_q;
    if (wr_en && !rd_en)      count_d = count_q + 1'b1;
    else if (!wr_en && rd_en) count_d = count_q - 1'b1;

    Out_valid = (count_q != '0);
    Out_X     = mem_q[rd_ptr_q].x;
    Out_C     = mem_q[rd_ptr_q].c;
    Out_R     = mem_q[rd_ptr_q].r;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      vld_sr_q <= '0;
      for (int i = 0; i < LATENCY; i++) x_sr_q[i] <= '0;
      for (int i = 0; i < DEPTH; i++)   mem_q[i]  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_sr_q <= vld_sr_d;
      x_sr_q   <= x_sr_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef ROOT_CHECK_EN
  logic       chk_err_q, chk_err_d;
  logic [7:0] diff;
  logic       bad;

  // A valid floor-sqrt satisfies c*c <= x <= c*c + 2c, with the upper nibble clear.
  always_comb begin
    diff      = x_tail - sq;
    bad       = (sq > x_tail) || (diff > {3'b000, c_tail, 1'b0}) || (Root_C[7:4] != 4'h0);
    chk_err_d = chk_err_q || (wr_en && bad);
  end

  always_ff @(posedge Clk) begin
    if (Rst) chk_err_q <= 1'b0;
    else     chk_err_q <= chk_err_d;
  end

  assign Chk_err = chk_err_q;
`else
  logic unused_root_bits;
  assign unused_root_bits = ^{Root_C[7:4], sq[7:5]};
`endif

endmodule

// File: tb/tb_root_drain.sv
// Bench for root_drain: behavioural ROOT pipeline plus queue-based reference of the drain FIFO.
// Directed vector table, hand sequences, random traffic; checker tests when ROOT_CHECK_EN is defined.
module tb_root_drain;
  localparam int LATENCY = 4;
  localparam int DEPTH   = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       In_valid = 1'b0;
  logic [7:0] In_X = 8'h00;
  logic       In_ready;
  logic [7:0] Root_C;
  logic       Out_valid;
  logic       Out_ready = 1'b0;
  logic [7:0] Out_X;
  logic [3:0] Out_C;
  logic [4:0] Out_R;
`ifdef ROOT_CHECK_EN
  logic       Chk_err;
`endif

  root_drain #(.LATENCY(LATENCY), .DEPTH(DEPTH), .AW(2)) dut (
    .Clk(Clk), .Rst(Rst), .In_valid(In_valid), .In_X(In_X), .In_ready(In_ready),
    .Root_C(Root_C), .Out_valid(Out_valid), .Out_ready(Out_ready),
    .Out_X(Out_X), .Out_C(Out_C), .Out_R(Out_R)
`ifdef ROOT_CHECK_EN
    , .Chk_err(Chk_err)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic logic [3:0] isqrt(input logic [7:0] x);
    int c = 0;
    while ((c + 1) * (c + 1) <= int'(x)) c++;
    return 4'(c);
  endfunction

  // ROOT itself is not reset; it samples In_X every edge whether or not it is a real transfer.
  logic [7:0] root_pipe [LATENCY];
  logic       force_en = 1'b0;
  logic [7:0] force_val = 8'h00;
  logic [3:0] hi_junk = 4'h0;
  always @(posedge Clk) begin
    root_pipe[0] <= In_X;
    for (int i = 1; i < LATENCY; i++) root_pipe[i] <= root_pipe[i-1];
  end
  assign Root_C = force_en ? force_val : {hi_junk, isqrt(root_pipe[LATENCY-1])};

  int n_chk = 0;
  int n_pass = 0;
  int n_acc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  logic [7:0] fq_x [$];
  logic [7:0] ifl_x [$];
  int         ifl_t [$];

  task automatic step(input bit v, input logic [7:0] x, input bit ordy, input bit rst);
    bit exp_rdy, acc, pop;
    int c;
    In_valid = v; In_X = x; Out_ready = ordy; Rst = rst;
    exp_rdy = (fq_x.size() + ifl_x.size()) < DEPTH;
    chk("in_ready", int'(In_ready), int'(exp_rdy));
    chk("out_valid", int'(Out_valid), int'(fq_x.size() != 0));
    if (fq_x.size() != 0) begin
      c = int'(isqrt(fq_x[0]));
      chk("out_x", int'(Out_X), int'(fq_x[0]));
      chk("out_c", int'(Out_C), c);
      chk("out_r", int'(Out_R), int'(fq_x[0]) - c * c);
    end
`ifdef ROOT_CHECK_EN
    chk("chk_err_idle", int'(Chk_err), 0);
`endif
    if (v && In_ready) n_acc++;
    acc = v && exp_rdy;
    pop = ordy && (fq_x.size() != 0);
    @(posedge Clk);
    if (rst) begin
      fq_x.delete(); ifl_x.delete(); ifl_t.delete();
    end else begin
      if (pop) void'(fq_x.pop_front());
      foreach (ifl_t[i]) ifl_t[i]--;
      while (ifl_t.size() != 0 && ifl_t[0] == 0) begin
        fq_x.push_back(ifl_x.pop_front());
        void'(ifl_t.pop_front());
      end
      if (acc) begin
        ifl_x.push_back(x);
        ifl_t.push_back(LATENCY);
      end
    end
    @(negedge Clk);
  endtask

  task automatic tick(input bit v, input logic [7:0] x, input bit ordy, input bit rst);
    In_valid = v; In_X = x; Out_ready = ordy; Rst = rst;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  typedef struct {
    bit         v;
    logic [7:0] x;
    bit         ordy;
    bit         e_rdy;
    bit         e_ov;
    bit         e_dat;
    logic [7:0] e_x;
    logic [3:0] e_c;
    logic [4:0] e_r;
  } vec_t;
  vec_t tbl [$];

  task automatic add_row(input bit v, input int x, input bit ordy, input bit e_rdy, input bit e_ov,
                         input bit e_dat, input int e_x, input int e_c, input int e_r);
    vec_t r;
    r.v = v; r.x = 8'(x); r.ordy = ordy; r.e_rdy = e_rdy; r.e_ov = e_ov;
    r.e_dat = e_dat; r.e_x = 8'(e_x); r.e_c = 4'(e_c); r.e_r = 5'(e_r);
    tbl.push_back(r);
  endtask

  initial begin
    logic [7:0] xa, xb, xc;
    repeat (2) @(negedge Clk);

    // single transfer, then five back-to-back operands (the fifth waits for credit)
    add_row(1, 200, 1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add_row(0, 0, 1, 1, 0, 0, 0, 0, 0);
    add_row(0, 0, 1, 1, 1, 1, 200, 14, 4);
    add_row(0, 0, 1, 1, 0, 1, 0, 0, 0);
    add_row(1, 0, 1, 1, 0, 1, 0, 0, 0);
    add_row(1, 1, 1, 1, 0, 0, 0, 0, 0);
    add_row(1, 255, 1, 1, 0, 0, 0, 0, 0);
    add_row(1, 16, 1, 1, 0, 0, 0, 0, 0);
    add_row(1, 63, 1, 0, 0, 0, 0, 0, 0);
    add_row(1, 63, 1, 0, 1, 1, 0, 0, 0);
    add_row(1, 63, 1, 1, 1, 1, 1, 1, 0);
    add_row(0, 0, 1, 1, 1, 1, 255, 15, 30);
    add_row(0, 0, 1, 1, 1, 1, 16, 4, 0);
    add_row(0, 0, 1, 1, 0, 0, 0, 0, 0);
    add_row(0, 0, 1, 1, 0, 0, 0, 0, 0);
    add_row(0, 0, 1, 1, 1, 1, 63, 7, 14);
    add_row(0, 0, 1, 1, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      chk($sformatf("tbl%0d_in_ready", i), int'(In_ready), int'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_out_valid", i), int'(Out_valid), int'(tbl[i].e_ov));
      if (tbl[i].e_dat) begin
        chk($sformatf("tbl%0d_out_x", i), int'(Out_X), int'(tbl[i].e_x));
        chk($sformatf("tbl%0d_out_c", i), int'(Out_C), int'(tbl[i].e_c));
        chk($sformatf("tbl%0d_out_r", i), int'(Out_R), int'(tbl[i].e_r));
      end
      step(tbl[i].v, tbl[i].x, tbl[i].ordy, 1'b0);
    end

    // fill with Out_ready low: exactly DEPTH credits, then credit returns one cycle after the first pop
    n_acc = 0;
    repeat (8) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("full_accepts", n_acc, DEPTH);
    chk("full_in_ready", int'(In_ready), 0);
    chk("full_out_valid", int'(Out_valid), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("credit_after_pop", int'(In_ready), 1);
    repeat (5) step(1'b0, 8'h00, 1'b1, 1'b0);

    // write and pop on the same edge with two entries queued
    xa = 8'd50; xb = 8'd81; xc = 8'd99;
    step(1'b1, xa, 1'b0, 1'b0);
    step(1'b1, xb, 1'b0, 1'b0);
    step(1'b1, xc, 1'b0, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("simul_head_a", int'(Out_X), int'(xa));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("simul_head_b", int'(Out_X), int'(xb));
    step(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("simul_drained", int'(Out_valid), 0);

    // reset while three transfers are in flight
    step(1'b1, 8'd10, 1'b1, 1'b0);
    step(1'b1, 8'd20, 1'b1, 1'b0);
    step(1'b1, 8'd30, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("rst_no_valid", int'(Out_valid), 0);
      chk("rst_in_ready", int'(In_ready), 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    step(1'b1, 8'd9, 1'b1, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rst_after_valid", int'(Out_valid), 1);
    chk("rst_after_c", int'(Out_C), 3);
    chk("rst_after_r", int'(Out_R), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // random traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] rx;
      rx = ($urandom_range(0, 3) == 0) ? 8'(($urandom_range(0, 15)) ** 2) : 8'($urandom);
`ifndef ROOT_CHECK_EN
      hi_junk = 4'($urandom);
`endif
      step($urandom_range(0, 3) != 0, rx, $urandom_range(0, 2) != 0, $urandom_range(0, 199) == 0);
    end
    hi_junk = 4'h0;

`ifdef ROOT_CHECK_EN
    step(1'b0, 8'h00, 1'b0, 1'b1);
    force_en = 1'b1; force_val = 8'd5;
    tick(1'b1, 8'd20, 1'b0, 1'b0);
    repeat (3) tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("chk_before_write", int'(Chk_err), 0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("chk_set", int'(Chk_err), 1);
    chk("chk_forced_c", int'(Out_C), 5);
    repeat (3) tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("chk_sticky", int'(Chk_err), 1);
    force_en = 1'b0;
    tick(1'b0, 8'h00, 1'b1, 1'b1);
    chk("chk_cleared", int'(Chk_err), 0);
    tick(1'b1, 8'd36, 1'b0, 1'b0);
    repeat (5) tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("chk_good_valid", int'(Out_valid), 1);
    chk("chk_good_c", int'(Out_C), 6);
    chk("chk_good", int'(Chk_err), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
